// File: rtl/crc9_pkg.sv
// Shared constants and state encoding for the serial CRC-9 checker/encoder family.
package crc9_pkg;

  localparam int DATA_W  = 10;
  localparam int CRC_W   = 9;
  localparam int FRAME_W = DATA_W + CRC_W;
  localparam int CNT_W   = 4;

  // G(y) = 1 + y + y^8 + y^9 with the y^9 term implied by the shift-out.
  localparam logic [CRC_W-1:0] POLY = 9'h103;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/crc9_lfsr_serial.sv
// Serial Galois LFSR for CRC-9, one message bit per enabled cycle, MSB first.
// Clear takes priority over enable. Holds its value when not enabled, so the
// register itself is the remainder once a message has been fed in.
module crc9_lfsr_serial
  import crc9_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_rem
);

  logic [CRC_W-1:0] r_lfsr;
  logic             w_fb;
  logic [CRC_W-1:0] w_lfsr_next;

  // Feedback: incoming bit xor the bit falling out of the top.
  always_comb begin
    w_fb        = i_bit ^ r_lfsr[CRC_W-1];
    w_lfsr_next = {r_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  end

  // Remainder register: clear, step on an accepted bit, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (i_clr) begin
      r_lfsr <= '0;
    end else if (i_en) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign o_rem = r_lfsr;

endmodule

// File: rtl/crc9_serial_checker.sv
// Receive-side CRC-9 checker: takes 10 data bits then 9 CRC bits MSB first,
// recovers the data word and reports the remainder over the whole codeword.
//
// Handshake: a bit is consumed on a rising edge where in_valid=1 while the
// FSM is in DATA or CRC and frame_start is low; in_valid=0 stalls with no
// state change. There is no back-pressure (no ready): the source must not
// present bits faster than one per cycle, and bits outside a frame are dropped.
module crc9_serial_checker
  import crc9_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome,
  output logic              done,
  output logic              crc_ok,
  output logic              crc_err,
  output state_t            dbg_state
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_data_sr;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_res_vld;
  logic               w_in_frame;
  logic               w_accept;
  logic               w_data_last;
  logic               w_crc_last;
  logic [CRC_W-1:0]   w_rem;

  // A start pulse always wins over a bit offered in the same cycle.
  always_comb begin
    w_in_frame  = (r_state == S_DATA) || (r_state == S_CRC);
    w_accept    = in_valid && !frame_start && w_in_frame;
    w_data_last = w_accept && (r_state == S_DATA) && (r_cnt == CNT_W'(DATA_W - 1));
    w_crc_last  = w_accept && (r_state == S_CRC)  && (r_cnt == CNT_W'(CRC_W - 1));
  end

  // Next-state logic; frame_start from any state (including DONE) opens a frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (frame_start) w_state_next = S_DATA;
      S_DATA: begin
        if (frame_start)      w_state_next = S_DATA;
        else if (w_data_last) w_state_next = S_CRC;
      end
      S_CRC: begin
        if (frame_start)     w_state_next = S_DATA;
        else if (w_crc_last) w_state_next = S_DONE;
      end
      S_DONE: w_state_next = frame_start ? S_DATA : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Bit counter: counts within the data phase, then again within the CRC phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (frame_start || w_data_last || w_crc_last) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Data shift register, MSB first; only data-phase bits land here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_sr <= '0;
    end else if (frame_start) begin
      r_data_sr <= '0;
    end else if (w_accept && (r_state == S_DATA)) begin
      r_data_sr <= {r_data_sr[DATA_W-2:0], in_bit};
    end
  end

  // Result capture on the edge that enters DONE; a new frame voids the verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_res_vld  <= 1'b0;
    end else if (w_crc_last) begin
      r_data_out <= r_data_sr;
      r_res_vld  <= 1'b1;
    end else if (frame_start) begin
      r_res_vld  <= 1'b0;
    end
  end

  // The LFSR stops stepping after the last CRC bit, so it holds the syndrome
  // until the next frame_start clears it.
  crc9_lfsr_serial u_lfsr (
    .clk   (clk),
    .rst_n (reset_n),
    .i_clr (frame_start),
    .i_en  (w_accept),
    .i_bit (in_bit),
    .o_rem (w_rem)
  );

  assign busy      = w_in_frame;
  assign done      = (r_state == S_DONE);
  assign data_out  = r_data_out;
  assign syndrome  = w_rem;
  assign crc_ok    = r_res_vld && (w_rem == '0);
  assign crc_err   = r_res_vld && (w_rem != '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_crc9_serial_checker.sv
// Directed plus randomized bench for crc9_serial_checker with a polynomial
// long-division reference model.
module tb_crc9_serial_checker;
  import crc9_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        in_valid;
  logic        in_bit;
  logic        busy;
  logic [9:0]  data_out;
  logic [8:0]  syndrome;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  state_t      dbg_state;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int done_seen = 0;
  logic last_done;
  int t_start;
  int t_done;

  crc9_serial_checker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .busy        (busy),
    .data_out    (data_out),
    .syndrome    (syndrome),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  // Remainder of a GF(2) polynomial (28 coefficients) divided by y^9+y^8+y+1.
  function automatic logic [8:0] poly_mod(input logic [27:0] v_in);
    logic [27:0] v;
    v = v_in;
    for (int i = 27; i >= 9; i--)
      if (v[i]) v = v ^ (28'h303 << (i - 9));
    return v[8:0];
  endfunction

  // Encoder CRC: D(y)*y^9 mod G.
  function automatic logic [8:0] model_crc(input logic [9:0] d);
    return poly_mod({9'b0, d, 9'b0});
  endfunction

  // Checker remainder after shifting all 19 bits through: C(y)*y^9 mod G.
  function automatic logic [8:0] model_syndrome(input logic [18:0] cw);
    return poly_mod({cw, 9'b0});
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Verdict flags must never both be set.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      assert (!(crc_ok === 1'b1 && crc_err === 1'b1)) else begin
        n_fail++;
        $error("FAIL ok_err_exclusive: observed ok=%0b err=%0b expected not both 1", crc_ok, crc_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle: sample done, then drive inputs for the next rising edge.
  task automatic step(input logic fs, input logic v, input logic b);
    @(negedge clk);
    last_done = done;
    if (done === 1'b1) done_seen++;
    frame_start = fs;
    in_valid    = v;
    in_bit      = b;
  endtask

  task automatic send_frame(input logic [18:0] cw, input bit do_start,
                            input int stall_a, input int stall_b,
                            input int stall_len, input bit rand_stall);
    if (do_start) step(1'b1, 1'b0, 1'b0);
    t_start = cyc;
    for (int i = 0; i < 19; i++) begin
      if (rand_stall)
        for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, cw[18-i]);
      if (i + 1 == stall_a || i + 1 == stall_b)
        repeat (stall_len) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Idle until done is seen (bounded); latency counted from the last bit.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      lat++;
      if (last_done === 1'b1) break;
    end
    t_done = cyc;
    check({tag, "_latency"}, lat, 1);
  endtask

  task automatic check_results(input string tag, input logic [18:0] cw);
    logic [8:0] es;
    es = model_syndrome(cw);
    check({tag, "_data"},     data_out, cw[18:9]);
    check({tag, "_syndrome"}, syndrome, es);
    check({tag, "_ok"},       crc_ok,   (es == 9'd0));
    check({tag, "_err"},      crc_err,  (es != 9'd0));
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [18:0] cw;
    logic [18:0] cw_b;
    logic [9:0]  d;
    int d0;
    int total_plain;
    int total_stall;

    reset_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",     busy,      0);
    check("rst_done",     done,      0);
    check("rst_data",     data_out,  0);
    check("rst_syndrome", syndrome,  0);
    check("rst_ok",       crc_ok,    0);
    check("rst_err",      crc_err,   0);
    check("rst_state",    dbg_state, S_IDLE);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);   // bits outside a frame are ignored
    step(1'b0, 1'b0, 1'b0);
    check("idle_ignore_busy", busy, 0);

    // 1: clean frame 10'h200 + 9'h004, no stalls.
    cw = {10'h200, 9'h004};
    d0 = done_seen;
    send_frame(cw, 1'b1, 0, 0, 0, 1'b0);
    check("t1_busy_last", busy, 1);
    wait_done("t1");
    total_plain = t_done - t_start;
    check_results("t1", cw);
    check("t1_ok_const", crc_ok, 1);
    step(1'b0, 1'b0, 1'b0);
    check("t1_done_one_cycle", last_done, 0);
    check("t1_ok_held", crc_ok, 1);
    check("t1_data_held", data_out, 10'h200);
    check("t1_pulses", done_seen - d0, 1);

    // 2: 10'h001 + 9'h103 with two 3-cycle stalls.
    cw = {10'h001, 9'h103};
    send_frame(cw, 1'b1, 5, 14, 3, 1'b0);
    wait_done("t2");
    total_stall = t_done - t_start;
    check_results("t2", cw);
    check("t2_ok_const", crc_ok, 1);
    check("t2_stall_delay", total_stall - total_plain, 6);

    // 3: 10'h3FF + 9'h1F8 with codeword bit 12 flipped.
    cw = {10'h3FF, 9'h1F8 ^ 9'h080};
    send_frame(cw, 1'b1, 0, 0, 0, 1'b0);
    wait_done("t3");
    check_results("t3", cw);
    check("t3_err_const", crc_err, 1);
    check("t3_syn_nonzero", (syndrome != 9'd0), 1);

    // 4: abort after 7 bits, then a full good frame.
    d0 = done_seen;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b1);   // restart; the concurrent bit is dropped
    cw = {10'h001, 9'h103};
    send_frame(cw, 1'b0, 0, 0, 0, 1'b0);
    wait_done("t4");
    check_results("t4", cw);
    check("t4_pulses", done_seen - d0, 1);

    // 5: reset after 15 bits, then 10'h200 + 9'h004.
    d0 = done_seen;
    send_frame({10'h155, 9'h0AA}, 1'b1, 0, 0, 0, 1'b0);   // overwritten below
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    @(negedge clk);
    check("t5_busy_before", busy, 1);
    reset_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
    #1;
    check("t5_busy",     busy,      0);
    check("t5_done",     done,      0);
    check("t5_data",     data_out,  0);
    check("t5_syndrome", syndrome,  0);
    check("t5_ok",       crc_ok,    0);
    check("t5_err",      crc_err,   0);
    check("t5_state",    dbg_state, S_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    cw = {10'h200, 9'h004};
    send_frame(cw, 1'b1, 0, 0, 0, 1'b0);
    wait_done("t5");
    check_results("t5", cw);
    check("t5_ok_const", crc_ok, 1);

    // 6: frame_start in the DONE cycle, back-to-back frames.
    d0 = done_seen;
    d = 10'($urandom_range(0, 1023));
    cw = {d, model_crc(d)};
    send_frame(cw, 1'b1, 0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t6a_done", last_done, 1);
    check_results("t6a", cw);
    d = 10'($urandom_range(0, 1023));
    cw_b = {d, model_crc(d) ^ 9'h011};
    send_frame(cw_b, 1'b0, 0, 0, 0, 1'b0);
    wait_done("t6b");
    check_results("t6b", cw_b);
    check("t6_pulses", done_seen - d0, 2);

    // Random frames, random stalls, half of them with a single flipped bit.
    for (int n = 0; n < 12; n++) begin
      d = 10'($urandom_range(0, 1023));
      cw = {d, model_crc(d)};
      if ($urandom_range(0, 1) == 1) cw = cw ^ (19'd1 << $urandom_range(0, 18));
      send_frame(cw, 1'b1, 0, 0, 0, 1'b1);
      wait_done("rnd");
      check_results("rnd", cw);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
    end

    step(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed no completion expected finish within limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc9_serial_checker.md
Name: crc9_serial_checker

Overview:
- Receive-side counterpart of the team's serial CRC-9 encoder (generator G(y)=1+y+y^8+y^9).
- Accepts a serial codeword MSB-first: 10 data bits followed by 9 CRC bits.
- Recomputes the remainder over all 19 bits and flags pass/fail.
- Presents the recovered 10-bit data word and the syndrome.
- Sits at the link receive end, after bit recovery and before the consumer of data words.

Parameters:
DATA_W, 10, data bits per frame
CRC_W, 9, CRC width (degree of G)
POLY, 9'h103, G without its top term (taps y^8, y^1, y^0)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse; opens a new frame (aborts any frame in progress)
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  serial codeword bit, MSB first
busy  out  1  frame in progress (DATA or CRC state)
data_out  out  DATA_W  recovered data word, held until next frame_start
syndrome  out  CRC_W  final remainder, held until next frame_start
done  out  1  one-cycle pulse when a frame completes
crc_ok  out  1  syndrome==0; valid while done=1 and held after
crc_err  out  1  syndrome!=0; valid while done=1 and held after

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, data_out=0, syndrome=0, done=0, crc_ok=0, crc_err=0, bit counter=0, LFSR=0.
- States: IDLE, DATA, CRC, DONE.
- IDLE: frame_start -> clear LFSR, counter and data shift register; go to DATA. All other inputs are ignored.
- LFSR step, applied on each accepted bit b:
  - fb = b ^ lfsr[8]
  - lfsr <= {lfsr[7:0],1'b0} ^ (fb ? POLY : 0)
- DATA: each in_valid=1 cycle accepts a bit.
  - The bit shifts into the data register (MSB first) and steps the LFSR; counter increments.
  - After the 10th accepted bit, go to CRC with counter=0.
- CRC: each in_valid=1 cycle steps the LFSR only.
  - After the 9th accepted bit, go to DONE.
- in_valid=0 in DATA or CRC: stall; no state, counter or LFSR change. No timeout.
- DONE (single cycle):
  - done=1; data_out, syndrome, crc_ok, crc_err update on the same edge that enters DONE.
  - Next cycle returns to IDLE.
  - Latency: done asserts the cycle after the 19th accepted bit's edge.
- Result outputs hold until the next frame_start, which clears crc_ok and crc_err to 0.
- frame_start in DATA or CRC: abort the current frame with no done pulse; restart as from IDLE. An in_valid in the same cycle is ignored.
- frame_start in the DONE cycle: done still pulses; the new frame starts next cycle (state goes to DATA, not IDLE).
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Invariants:
  - busy=1 exactly in DATA or CRC.
  - crc_ok and crc_err are never both 1.
  - done never asserts without 19 accepted bits since the last frame_start.
- Bit order is MSB first, matching the encoder's output order. Codeword is D(y)*y^9 + R(y).

Decomposition:
- Package crc9_pkg holds DATA_W, CRC_W, POLY, the state enum (IDLE/DATA/CRC/DONE) and a FRAME_W=19 constant.
- Sub-module crc9_lfsr_serial: the 9-bit LFSR register with clr and en inputs, serial bit input and parallel remainder output. The encoder can reuse it.

Test Plan:
1. Codeword 10'b1000000000 + 9'h004, in_valid held high → done pulses 1 cycle after the 19th bit; data_out=10'h200, syndrome=0, crc_ok=1, crc_err=0.
2. Codeword 10'h001 + 9'h103, with in_valid deasserted for 3 cycles after bit 5 and after bit 14 → same result as an unstalled frame: data_out=10'h001, crc_ok=1; done arrives 6 cycles later than in the unstalled case.
3. Codeword 10'h3FF + 9'h1F8 with bit 12 flipped (CRC bit value 9'h1F8^9'h080) → crc_err=1, syndrome!=0, data_out=10'h3FF.
4. frame_start after 7 bits of a frame, then a full valid frame 10'h001 + 9'h103 → exactly one done pulse, for the second frame only, with crc_ok=1.
5. reset_n low for 1 cycle after 15 bits → all outputs 0 immediately; the following valid frame 10'h200 + 9'h004 passes.
6. frame_start asserted in the DONE cycle, then back-to-back frames → both done pulses present; the second frame's results are correct and independent of the first.
